// File: rtl/pulse_launcher.sv
// Queues single-cycle event pulses and launches them one at a time towards the
// CDC handshake, waiting for the full ack rise/fall round trip between launches.
module pulse_launcher #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             event_in,
    input  logic             ack,
    input  logic             clr_err,
    output logic             data_from_fast,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [15:0]      TMR_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [15:0]      tmr_q, tmr_d;
    logic             dfast_q, busy_q, ovf_q, tmo_q;
    logic             launch, ovf_set, tmo_set;

    assign launch = (state_q == IDLE) && (pend_q != '0) && !ack;

    always_comb begin
        state_d = state_q;
        tmo_set = 1'b0;
        case (state_q)
            IDLE:    if (launch) state_d = SEND;
            SEND:    state_d = WAIT_HI;
            WAIT_HI: begin
                if (ack) state_d = WAIT_LO;
                else if (tmr_q == TMR_LAST) begin
                    state_d = IDLE;
                    tmo_set = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!ack) state_d = IDLE;
                else if (tmr_q == TMR_LAST) begin
                    state_d = IDLE;
                    tmo_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A launch and a new event in the same edge cancel; saturation drops the event.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (event_in && !launch) begin
            if (pend_q == PEND_MAX) ovf_set = 1'b1;
            else                    pend_d  = pend_q + 1'b1;
        end else if (!event_in && launch) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_comb begin
        tmr_d = tmr_q;
        if (state_d != state_q)
            tmr_d = '0;
        else if ((state_q == WAIT_HI || state_q == WAIT_LO) && tmr_q != '1)
            tmr_d = tmr_q + 1'b1;
    end

    always_ff @(posedge clk_fast) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            tmr_q   <= '0;
            dfast_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
            dfast_q <= (state_d == SEND);
            busy_q  <= (state_d != IDLE);
            ovf_q   <= (ovf_q & ~clr_err) | ovf_set;
            tmo_q   <= (tmo_q & ~clr_err) | tmo_set;
        end
    end

    assign data_from_fast = dfast_q;
    assign pending        = pend_q;
    assign busy           = busy_q;
    assign overflow       = ovf_q;
    assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_pulse_launcher.sv
// Bench for pulse_launcher: directed scenarios plus randomized traffic against
// a cycle-level behavioural model driven by an ack responder with random delays.
module tb_pulse_launcher;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int MAXP    = (1 << CNT_W) - 1;

    logic             clk_fast = 1'b0;
    logic             rst = 1'b0, event_in = 1'b0, ack = 1'b0, clr_err = 1'b0;
    logic             data_from_fast, busy, overflow, timeout_err;
    logic [CNT_W-1:0] pending;

    pulse_launcher #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_fast(clk_fast), .rst(rst), .event_in(event_in), .ack(ack),
        .clr_err(clr_err), .data_from_fast(data_from_fast), .pending(pending),
        .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk_fast = ~clk_fast;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 launching, 2 awaiting ack high, 3 awaiting ack low.
    int m_ph, m_pend, m_wait;
    bit m_dfast, m_busy, m_ovf, m_to;

    task automatic model_step(input bit ev, input bit a, input bit clr, input bit rv);
        bit fire, ovf_ev, to_ev, done;
        int np;
        if (!rv) begin
            m_ph = 0; m_pend = 0; m_wait = 0;
            m_dfast = 0; m_busy = 0; m_ovf = 0; m_to = 0;
            return;
        end
        fire   = (m_ph == 0) && (m_pend > 0) && !a;
        np     = m_pend + int'(ev) - int'(fire);
        ovf_ev = 0;
        if (np > MAXP) begin np = MAXP; ovf_ev = 1; end
        m_pend = np;
        to_ev  = 0;
        case (m_ph)
            0: if (fire) m_ph = 1;
            1: begin m_ph = 2; m_wait = 0; end
            default: begin
                done = (m_ph == 2) ? a : !a;
                if (done) begin
                    m_ph = (m_ph == 2) ? 3 : 0;
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) begin m_ph = 0; m_wait = 0; to_ev = 1; end
                end
            end
        endcase
        m_dfast = fire;
        m_busy  = (m_ph != 0);
        m_ovf   = (m_ovf && !clr) || ovf_ev;
        m_to    = (m_to && !clr) || to_ev;
    endtask

    // Ack responder: 0 in fix_* means pick a random delay.
    int rise_cnt = 0, fall_cnt = 0, fix_rise = 0, fix_fall = 0;
    bit rsp_off = 0;

    task automatic step(input bit ev, input bit clr, input bit rv);
        bit a_s;
        event_in = ev; clr_err = clr; rst = rv;
        a_s = ack;
        @(posedge clk_fast); #1;
        model_step(ev, a_s, clr, rv);
        chk("dfast", int'(data_from_fast), int'(m_dfast));
        chk("pend",  int'(pending),        m_pend);
        chk("busy",  int'(busy),           int'(m_busy));
        chk("ovf",   int'(overflow),       int'(m_ovf));
        chk("tmo",   int'(timeout_err),    int'(m_to));
        if (data_from_fast && !rsp_off) begin
            rise_cnt = (fix_rise != 0) ? fix_rise : int'($urandom_range(1, 12));
        end else if (!ack && rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
                ack = 1'b1;
                fall_cnt = (fix_fall != 0) ? fix_fall : int'($urandom_range(1, 12));
            end
        end else if (ack && fall_cnt > 0) begin
            fall_cnt--;
            if (fall_cnt == 0) ack = 1'b0;
        end
    endtask

    initial begin
        // Reset held with events present
        repeat (5) step(1, 0, 0);
        chk("rst_pend", int'(pending), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dfast", int'(data_from_fast), 0);
        step(1, 0, 1);
        chk("rel_pend", int'(pending), 1);

        // Single event with fixed ack round trip
        fix_rise = 3; fix_fall = 4;
        step(0, 0, 1);
        chk("lat_dfast", int'(data_from_fast), 1);
        chk("lat_pend", int'(pending), 0);
        chk("lat_busy", int'(busy), 1);
        step(0, 0, 1);
        chk("lat_dfast_off", int'(data_from_fast), 0);
        repeat (15) step(0, 0, 1);
        chk("single_idle", int'(busy), 0);

        // Burst into saturation without responder
        step(0, 0, 0);
        rsp_off = 1;
        repeat (20) step(1, 0, 1);
        chk("sat_pend", int'(pending), 15);
        chk("sat_ovf", int'(overflow), 1);
        step(0, 1, 1);
        chk("clr_ovf", int'(overflow), 0);

        // Timeout in WAIT_HI
        step(0, 0, 0);
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (7) step(0, 0, 1);
        chk("to_busy_hold", int'(busy), 1);
        step(0, 0, 1);
        chk("to_busy_drop", int'(busy), 0);
        chk("to_err", int'(timeout_err), 1);
        chk("to_pend", int'(pending), 0);

        // Event on the launch edge
        step(0, 0, 0);
        rsp_off = 0; fix_rise = 2; fix_fall = 2;
        step(1, 0, 1);
        step(1, 0, 1);
        chk("sim_pend", int'(pending), 1);
        chk("sim_dfast", int'(data_from_fast), 1);
        repeat (30) step(0, 0, 1);
        chk("sim_drain", int'(pending), 0);

        // Reset while in WAIT_LO with ack high
        step(0, 0, 0);
        fix_rise = 1; fix_fall = 6;
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("mid_ack", int'(ack), 1);
        step(0, 0, 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_pend", int'(pending), 0);
        step(1, 0, 1);
        repeat (3) begin
            step(0, 0, 1);
            chk("mid_hold", int'(data_from_fast), 0);
        end
        step(0, 0, 1);
        chk("mid_launch", int'(data_from_fast), 1);
        repeat (20) step(0, 0, 1);

        // Randomized traffic
        fix_rise = 0; fix_fall = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) rsp_off = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 399) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pulse_launcher.md
# pulse_launcher

Fast-domain feeder that sits directly upstream of the single-bit CDC `handshake` block. It queues single-cycle event pulses from fast-domain logic and launches them one at a time as `data_from_fast` pulses. It waits for the full `ack` rise/fall round trip before launching the next pulse, so back-to-back or bursty events are never merged or lost in the crossing. It also reports backlog, saturation overflow and handshake timeout.

## Interface
- `CNT_W`, default 4: width of the pending-event counter; max backlog is 2^CNT_W-1.
- `TIMEOUT`, default 64: max `clk_fast` cycles spent in either ack wait phase, range 2..65535.
- `clk_fast`  in  1: sole clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `event_in`  in  1: event strobe, sampled every cycle; each high cycle is one event.
- `ack`  in  1: acknowledge from `handshake`, already in the `clk_fast` domain.
- `clr_err`  in  1: clears the sticky flags.
- `data_from_fast`  out  1: launch pulse to `handshake`, registered, exactly one cycle wide.
- `pending`  out  CNT_W: events queued and not yet launched.
- `busy`  out  1: high whenever state is not IDLE.
- `overflow`  out  1: sticky; an event was dropped at saturation.
- `timeout_err`  out  1: sticky; an ack phase timed out.

## Operation
- Reset (`rst`=0 at an edge): state IDLE, `pending`=0, timer=0; all outputs 0. Reset applies in any state, including mid-handshake.
- States:
  - IDLE -> SEND when `pending`!=0 and `ack`=0. If `ack` is still high (e.g. after reset mid-handshake), remain in IDLE.
  - SEND (1 cycle): `data_from_fast`=1. Unconditionally -> WAIT_HI.
  - WAIT_HI: `ack`=1 -> WAIT_LO. Otherwise, if timer = TIMEOUT-1, go to IDLE and set `timeout_err`.
  - WAIT_LO: `ack`=0 -> IDLE. Otherwise, if timer = TIMEOUT-1, go to IDLE and set `timeout_err`.
- `pending` arithmetic, evaluated at each edge:
  - Increment when `event_in`=1.
  - Decrement on the edge that enters SEND.
  - Both in the same edge: unchanged.
  - Increment when `pending`=2^CNT_W-1 with no decrement in that edge: the event is dropped, `pending` holds at max, and `overflow` is set.
  - No underflow is possible: SEND is only entered when `pending`!=0.
- Timer:
  - Cleared on every state change.
  - Increments each cycle in WAIT_HI/WAIT_LO.
  - Saturates; never wraps.
- A timed-out event is consumed and not retried.
- `clr_err`=1 clears both sticky flags at the next edge. If a new error condition occurs in that same edge, set wins.
- `busy` = (state != IDLE), registered together with the state.

## Timing
- Latency from an idle block (`pending`=0, `ack`=0): `event_in` sampled at edge k gives `pending`=1 after edge k. After edge k+1: `data_from_fast`=1, `pending`=0, `busy`=1. After edge k+2: `data_from_fast`=0.
- `data_from_fast` is never high for two consecutive cycles.
- Minimum spacing between launches is 1 + (cycles in WAIT_HI) + (cycles in WAIT_LO) + 1 IDLE cycle.
- `event_in` high for N consecutive cycles queues N events (below saturation), which produce N separate launches.
- `ack` response in WAIT_HI/WAIT_LO takes effect at the next edge; the state changes one cycle after `ack` toggles.

## Test plan
- Reset: hold `rst`=0 for 5 edges with `event_in`=1 -> all outputs 0, `pending`=0; release -> `pending`=1 one edge later.
- Single event:
  - Stimulus: `event_in` pulse at edge k; model `ack` rising 3 cycles after the launch and falling 4 cycles after that.
  - Required: `data_from_fast` high after edge k+1 for 1 cycle; `busy` falls one edge after `ack` falls.
- Burst and saturation:
  - Stimulus: CNT_W=4, `ack` held 0 (no responder), `event_in` high for 20 cycles.
  - Required: `pending` saturates at 15 and `overflow`=1. At most one event is decremented while in SEND, so after the burst `pending`=15 and `overflow`=1.
- Timeout: TIMEOUT=8, `ack` never rises -> state returns to IDLE 8 cycles after entering WAIT_HI; `timeout_err`=1; `pending` reduced by 1.
- Simultaneous events:
  - Stimulus: `event_in`=1 on the edge entering SEND with `pending`=1.
  - Required: `pending` stays 1. A second launch follows after `ack` completes its round trip.
- Reset mid-handshake:
  - Stimulus: `rst`=0 while in WAIT_LO with `ack`=1.
  - Required: IDLE, `pending`=0. A new event does not launch until `ack` falls; the first launch comes one edge after `ack` falls.
